// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: two write lanes, packed read ports and the ready flag.
// The master side (decode/writeback) drives writes and read addresses; the slave is the register file.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                     ready_o;
  logic                     we0_i;
  logic [ADDR_W-1:0]        waddr0_i;
  logic [DATA_W-1:0]        wdata0_i;
  logic                     we1_i;
  logic [ADDR_W-1:0]        waddr1_i;
  logic [DATA_W-1:0]        wdata1_i;
  logic [NUM_RD*ADDR_W-1:0] raddr_i;
  logic [NUM_RD*DATA_W-1:0] rdata_o;

  modport master (
    output we0_i, waddr0_i, wdata0_i,
    output we1_i, waddr1_i, wdata1_i,
    output raddr_i,
    input  ready_o, rdata_o
  );

  modport slave (
    input  we0_i, waddr0_i, wdata0_i,
    input  we1_i, waddr1_i, wdata1_i,
    input  raddr_i,
    output ready_o, rdata_o
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with two write lanes, a post-reset clear sequencer and ready flag.
// Optional macro RF_BYPASS_EN forwards same-cycle write data to matching read ports.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  regfile_mp_if.slave rf
);
  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam bit                ZERO_EN   = (ZERO_REG != 32'sd0);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e                   state_q;
  logic [ADDR_W-1:0]        clr_cnt_q;
  logic [ADDR_W-1:0]        clr_cnt_d;
  logic                     ready_q;
  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic                     wr0_en_s;
  logic                     wr1_en_s;
  logic [NUM_RD*DATA_W-1:0] rdata_s;

  // A lane only commits in RUN; the hardwired zero entry swallows its writes.
  always_comb begin
    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
    wr0_en_s  = (state_q == RUN) && rf.we0_i &&
                !(ZERO_EN && (rf.waddr0_i == ADDR_ZERO));
    wr1_en_s  = (state_q == RUN) && rf.we1_i &&
                !(ZERO_EN && (rf.waddr1_i == ADDR_ZERO));
  end

  // Sequencer plus storage; lane 1 is written last so it wins an address clash.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          mem_q[clr_cnt_q] <= '0;
          clr_cnt_q        <= clr_cnt_d;
          if (clr_cnt_q == LAST_ADDR) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          if (wr0_en_s) mem_q[rf.waddr0_i] <= rf.wdata0_i;
          if (wr1_en_s) mem_q[rf.waddr1_i] <= rf.wdata1_i;
        end
        default: begin
          state_q   <= CLEAR;
          clr_cnt_q <= '0;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] raddr_s;
    assign raddr_s = rf.raddr_i[k*ADDR_W +: ADDR_W];

    // Reads are forced to zero while clearing so uninitialised storage never leaks out.
    always_comb begin
      if (state_q != RUN) begin
        rdata_s[k*DATA_W +: DATA_W] = '0;
      end else if (ZERO_EN && (raddr_s == ADDR_ZERO)) begin
        rdata_s[k*DATA_W +: DATA_W] = '0;
`ifdef RF_BYPASS_EN
      end else if (wr1_en_s && (rf.waddr1_i == raddr_s)) begin
        rdata_s[k*DATA_W +: DATA_W] = rf.wdata1_i;
      end else if (wr0_en_s && (rf.waddr0_i == raddr_s)) begin
        rdata_s[k*DATA_W +: DATA_W] = rf.wdata0_i;
`endif
      end else begin
        rdata_s[k*DATA_W +: DATA_W] = mem_q[raddr_s];
      end
    end
  end

  assign rf.rdata_o = rdata_s;
  assign rf.ready_o = ready_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench: two DUTs (ZERO_REG=1 and ZERO_REG=0) share stimulus and are compared
// every cycle against an array-based model, plus directed literal checks.
module tb_regfile_mp;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 4;
  localparam int DEPTH = 32;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             we0, we1;
  logic [AW-1:0]    wa0, wa1;
  logic [DW-1:0]    wd0, wd1;
  logic [NR*AW-1:0] ra;
  logic [NR*DW-1:0] rd1, rd0;
  logic             rdy1, rdy0;

  int tests = 0;
  int fails = 0;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) if1 ();
  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) if0 ();

  assign if1.we0_i = we0;  assign if1.waddr0_i = wa0;  assign if1.wdata0_i = wd0;
  assign if1.we1_i = we1;  assign if1.waddr1_i = wa1;  assign if1.wdata1_i = wd1;
  assign if1.raddr_i = ra;
  assign if0.we0_i = we0;  assign if0.waddr0_i = wa0;  assign if0.wdata0_i = wd0;
  assign if0.we1_i = we1;  assign if0.waddr1_i = wa1;  assign if0.wdata1_i = wd1;
  assign if0.raddr_i = ra;
  assign rd1 = if1.rdata_o;  assign rdy1 = if1.ready_o;
  assign rd0 = if0.rdata_o;  assign rdy0 = if0.ready_o;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .rf(if1.slave));
  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .rf(if0.slave));

  // Reference model: contents per ZERO_REG flavour, and clear progress as a plain edge count.
  logic [DW-1:0] mem1 [DEPTH];
  logic [DW-1:0] mem0 [DEPTH];
  bit            started = 1'b0;
  bit            mready  = 1'b0;
  int            ccnt    = 0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      started = 1'b1; mready = 1'b0; ccnt = 0;
    end else if (started && !mready) begin
      ccnt++;
      if (ccnt == DEPTH) begin
        mready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin mem1[i] = '0; mem0[i] = '0; end
      end
    end else if (mready) begin
      if (we0) begin mem0[wa0] = wd0; if (wa0 != 0) mem1[wa0] = wd0; end
      if (we1) begin mem0[wa1] = wd1; if (wa1 != 0) mem1[wa1] = wd1; end
    end
  end

  function automatic logic [DW-1:0] exp_rd(bit zr, logic [AW-1:0] a);
    if (!mready) return '0;
    if (zr && a == 0) return '0;
    if (BYP && we1 && wa1 == a) return wd1;
    if (BYP && we0 && wa0 == a && !(zr && wa0 == 0)) return wd0;
    return zr ? mem1[a] : mem0[a];
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both DUTs against the model.
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("ready_zr1", {31'd0, rdy1}, {31'd0, mready});
      chk("ready_zr0", {31'd0, rdy0}, {31'd0, mready});
      for (int p = 0; p < NR; p++) begin
        chk($sformatf("rd_zr1_p%0d", p), rd1[p*DW +: DW], exp_rd(1'b1, ra[p*AW +: AW]));
        chk($sformatf("rd_zr0_p%0d", p), rd0[p*DW +: DW], exp_rd(1'b0, ra[p*AW +: AW]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                    input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    we0 = e0; wa0 = a0; wd0 = d0; we1 = e1; wa1 = a1; wd1 = d1;
    step();
    we0 = 1'b0; we1 = 1'b0;
  endtask

  task automatic set_ra(input int p, input logic [AW-1:0] a);
    ra[p*AW +: AW] = a;
  endtask

  // Runs the clear window with rst low; lane 0 keeps issuing random writes that must be dropped.
  task automatic wait_clear(input string tag);
    for (int i = 0; i < DEPTH - 1; i++) begin
      wa0 = AW'($urandom); wd0 = $urandom;
      step();
    end
    chk({tag, "_ready_low"}, {31'd0, rdy1}, 32'd0);
    step();
    chk({tag, "_ready_high"}, {31'd0, rdy1}, 32'd1);
    chk({tag, "_ready_high_zr0"}, {31'd0, rdy0}, 32'd1);
    we0 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we0 = 1'b0; we1 = 1'b0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; ra = '0;
    repeat (2) step();
    rst = 1'b0;
    wait_clear("init");

    // Load every entry, then reset with lane 0 writing throughout the clear.
    for (int a = 0; a < DEPTH; a++) wr(1'b1, AW'(a), $urandom, 1'b0, '0, '0);
    rst = 1'b1; we0 = 1'b1; step();
    rst = 1'b0;
    wait_clear("clear");
    for (int a = 0; a < DEPTH; a += NR) begin
      for (int p = 0; p < NR; p++) set_ra(p, AW'(a + p));
      #1;
      for (int p = 0; p < NR; p++) begin
        chk("cleared_zr1", rd1[p*DW +: DW], 32'h0000_0000);
        chk("cleared_zr0", rd0[p*DW +: DW], 32'h0000_0000);
      end
    end

    // Reset again ten edges into the clear.
    rst = 1'b1; step();
    rst = 1'b0; repeat (10) step();
    rst = 1'b1; step();
    rst = 1'b0;
    wait_clear("midclear");

    wr(1'b1, 5'd7, 32'hAAAA_0000, 1'b1, 5'd7, 32'h5555_FFFF);
    set_ra(0, 5'd7); #1;
    chk("conflict_lane1_wins", rd1[0 +: DW], 32'h5555_FFFF);
    wr(1'b1, 5'd3, 32'h0303_0303, 1'b1, 5'd4, 32'h0404_0404);
    set_ra(0, 5'd3); set_ra(1, 5'd4); #1;
    chk("dual_addr3", rd1[0 +: DW], 32'h0303_0303);
    chk("dual_addr4", rd1[DW +: DW], 32'h0404_0404);

    wr(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 5'd0, 32'hDEAD_BEEF);
    ra = '0; #1;
    for (int p = 0; p < NR; p++) begin
      chk("zero_reg_on", rd1[p*DW +: DW], 32'h0000_0000);
      chk("zero_reg_off", rd0[p*DW +: DW], 32'hDEAD_BEEF);
    end

    wr(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
    wr(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    set_ra(0, 5'd4); set_ra(1, 5'd3); set_ra(2, 5'd2); set_ra(3, 5'd1); #1;
    chk("mp_p0", rd1[0*DW +: DW], 32'h44);
    chk("mp_p1", rd1[1*DW +: DW], 32'h33);
    chk("mp_p2", rd1[2*DW +: DW], 32'h22);
    chk("mp_p3", rd1[3*DW +: DW], 32'h11);

    wr(1'b0, '0, '0, 1'b1, 5'd9, 32'h1);
    set_ra(0, 5'd9); we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h2; #1;
    chk("rw_same_cycle", rd1[0 +: DW], BYP ? 32'h2 : 32'h1);
    step();
    we1 = 1'b0; #1;
    chk("rw_after_edge", rd1[0 +: DW], 32'h2);

    // Random traffic with occasional resets; the compare process does the checking.
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 249) == 0);
      we0 = $urandom_range(0, 1); we1 = $urandom_range(0, 1);
      wa0 = AW'($urandom);
      wa1 = ($urandom_range(0, 3) == 0) ? wa0 : AW'($urandom);
      wd0 = $urandom; wd1 = $urandom;
      for (int p = 0; p < NR; p++)
        set_ra(p, ($urandom_range(0, 2) == 0) ? wa1 : AW'($urandom));
      step();
    end
    rst = 1'b0; we0 = 1'b0; we1 = 1'b0;
    repeat (DEPTH + 4) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
